mem_port_arbiter: RTL and testbench

- Shares the single Ram port between two requesters: instruction fetch (IF) and load/store (LS) in the control sequencer.
- Requesters use a req/gnt/rvalid handshake. The arbiter registers each accepted request, drives the Ram for one cycle, then returns the read data or a write acknowledge.
- LS has fixed priority over IF, plus an anti-starvation counter so fetch always progresses.

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported Ram between instruction fetch (IF) and load/store (LS).
// LS has fixed priority; a starvation counter forces IF through after repeated losses.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_starve_cnt;
    logic              r_owner_ls;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata;

    logic w_arb;
    logic w_ls_win;
    logic w_if_win;

    // Gating with rst keeps both grants low while reset is held, so no
    // request is accepted before the first cycle after release.
    always_comb begin
        w_arb    = (r_state != ACCESS) && !rst;
        w_ls_win = w_arb && ls_req && !(if_req && (r_starve_cnt == LIMIT));
        w_if_win = w_arb && if_req && !w_ls_win;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = (w_ls_win || w_if_win) ? ACCESS : IDLE;
            ACCESS:  w_next_state = RESP;
            RESP:    w_next_state = (w_ls_win || w_if_win) ? ACCESS : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        if_gnt    = w_if_win;
        ls_gnt    = w_ls_win;
        mem_we    = (r_state == ACCESS) && r_we;
        if_rvalid = (r_state == RESP) && !r_owner_ls;
        ls_rvalid = (r_state == RESP) && r_owner_ls;
    end

    // Request latch, read-data capture and starvation tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_owner_ls   <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_if_rdata   <= '0;
            r_ls_rdata   <= '0;
        end else begin
            if (w_ls_win) begin
                r_owner_ls <= 1'b1;
                r_we       <= ls_we;
                r_addr     <= ls_addr;
                r_wdata    <= ls_wdata;
            end else if (w_if_win) begin
                r_owner_ls <= 1'b0;
                r_we       <= 1'b0;
                r_addr     <= if_addr;
            end

            if (w_if_win) begin
                r_starve_cnt <= '0;
            end else if (w_ls_win && if_req && (r_starve_cnt != LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end

            if ((r_state == ACCESS) && !r_we) begin
                if (r_owner_ls) begin
                    r_ls_rdata <= mem_rdata;
                end else begin
                    r_if_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign ls_rdata  = r_ls_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expected responses,
// a negedge monitor pops and compares them whenever an rvalid pulse appears.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    typedef struct {
        bit          isStore;
        logic [31:0] data;
    } expT;

    expT         ifExpQ[$];
    expT         lsExpQ[$];
    int          ifGntCyc[$];
    int          lsGntCyc[$];
    logic [31:0] tbMem [256];
    logic [31:0] lastIf = '0;
    logic [31:0] lastLs = '0;
    string       grantLog = "";
    int          cycle = 0;
    int          weCycles = 0;
    int          ifRvalidCnt = 0;
    int          checks = 0;
    int          errors = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Ram model: combinational read, write on the clock edge while mem_we is high.
    assign mem_rdata = tbMem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_we) tbMem[mem_addr[7:0]] = mem_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: grant exclusivity, grant log, latency and response data.
    always @(negedge clk) begin
        if (rst) begin
            ifGntCyc.delete();
            lsGntCyc.delete();
        end else begin
            if (if_gnt || ls_gnt) checkOutput("single grant", 32'(if_gnt && ls_gnt), 32'd0);
            if (if_gnt) begin
                ifGntCyc.push_back(cycle);
                grantLog = {grantLog, "I"};
            end
            if (ls_gnt) begin
                lsGntCyc.push_back(cycle);
                grantLog = {grantLog, "L"};
            end
            if (mem_we) weCycles++;
            if (if_rvalid) begin
                expT e;
                ifRvalidCnt++;
                if (ifExpQ.size() == 0) begin
                    checkOutput("unexpected if_rvalid", 32'd1, 32'd0);
                end else begin
                    e = ifExpQ.pop_front();
                    checkOutput("if_rdata", if_rdata, e.data);
                    lastIf = e.data;
                    if (ifGntCyc.size() != 0)
                        checkOutput("if latency", 32'(cycle - ifGntCyc.pop_front()), 32'd2);
                end
            end
            if (ls_rvalid) begin
                expT e;
                if (lsExpQ.size() == 0) begin
                    checkOutput("unexpected ls_rvalid", 32'd1, 32'd0);
                end else begin
                    e = lsExpQ.pop_front();
                    if (e.isStore) begin
                        checkOutput("ls_rdata held on store", ls_rdata, lastLs);
                    end else begin
                        checkOutput("ls_rdata", ls_rdata, e.data);
                        lastLs = e.data;
                    end
                    if (lsGntCyc.size() != 0)
                        checkOutput("ls latency", 32'(cycle - lsGntCyc.pop_front()), 32'd2);
                end
            end
        end
    end

    // One request on either port: push the expectation, hold req until the
    // grant, then check the Ram bus in the access cycle.
    task automatic applyStimulus(input bit isLs, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expData,
                                 input bit keep, input bit abortRst, output int gntCycle);
        expT e;
        int  n;
        e.isStore = isLs && we;
        e.data    = expData;
        if (isLs) begin
            lsExpQ.push_back(e);
            ls_we    = we;
            ls_addr  = addr;
            ls_wdata = wdata;
            ls_req   = 1'b1;
        end else begin
            ifExpQ.push_back(e);
            if_addr = addr;
            if_req  = 1'b1;
        end
        n        = 0;
        gntCycle = -1;
        do begin
            @(negedge clk);
            n++;
        end while (!(isLs ? ls_gnt : if_gnt) && n < 100);
        if (!(isLs ? ls_gnt : if_gnt)) begin
            checks++;
            errors++;
            $display("[TB] FAIL grant timeout: port %s addr %h", isLs ? "LS" : "IF", addr);
            if (isLs) begin
                ls_req = 1'b0;
                void'(lsExpQ.pop_back());
            end else begin
                if_req = 1'b0;
                void'(ifExpQ.pop_back());
            end
            return;
        end
        gntCycle = cycle;
        @(posedge clk);
        #1;
        if (!keep || abortRst) begin
            if (isLs) ls_req = 1'b0;
            else      if_req = 1'b0;
        end
        if (abortRst) begin
            checkOutput("mem_we before reset", 32'(mem_we), 32'd1);
            rst = 1'b1;
            #1;
            checkOutput("mem_we async drop", 32'(mem_we), 32'd0);
            void'(lsExpQ.pop_back());
            lastIf = '0;
            lastLs = '0;
            @(posedge clk);
            @(posedge clk);
            #1 rst = 1'b0;
            return;
        end
        @(negedge clk);
        checkOutput("mem_addr in access", mem_addr, addr);
        checkOutput("mem_we in access", 32'(mem_we), 32'(we));
        if (we) checkOutput("mem_wdata in access", mem_wdata, wdata);
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((ifExpQ.size() != 0 || lsExpQ.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard drained", 32'(ifExpQ.size() + lsExpQ.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkLog(input string name, input string exp);
        checks++;
        if (grantLog != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %s expected %s", name, grantLog, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int prevG;
        int we0;
        int rv0;
        int idleBad;
        logic [31:0] burstAddr [4];
        logic [31:0] burstData [4];

        for (int i = 0; i < 256; i++) tbMem[i] = '0;
        tbMem[8'hFF] = 32'h07B00293;
        tbMem[8'h10] = 32'h11112222;
        tbMem[8'h20] = 32'h33334444;
        tbMem[8'h24] = 32'h55556666;
        tbMem[8'h30] = 32'hA0A0A0A0;
        tbMem[8'h34] = 32'hB1B1B1B1;
        tbMem[8'h38] = 32'hC2C2C2C2;
        tbMem[8'h3C] = 32'hD3D3D3D3;
        burstAddr[0] = 32'h30; burstData[0] = 32'hA0A0A0A0;
        burstAddr[1] = 32'h34; burstData[1] = 32'hB1B1B1B1;
        burstAddr[2] = 32'h38; burstData[2] = 32'hC2C2C2C2;
        burstAddr[3] = 32'h3C; burstData[3] = 32'hD3D3D3D3;

        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset control outputs",
                    32'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_we}), 32'd0);
        checkOutput("reset data outputs", if_rdata | ls_rdata | mem_addr | mem_wdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] single fetch");
        applyStimulus(1'b0, 1'b0, 32'hFF, '0, 32'h07B00293, 1'b0, 1'b0, g);
        waitDrain();
        checkOutput("ls_rdata untouched by fetch", ls_rdata, 32'd0);

        $display("[TB] store then load");
        we0 = weCycles;
        applyStimulus(1'b1, 1'b1, 32'h79, 32'h58, '0, 1'b0, 1'b0, g);
        waitDrain();
        checkOutput("store mem_we cycles", 32'(weCycles - we0), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h79, '0, 32'h00000058, 1'b0, 1'b0, g);
        waitDrain();

        $display("[TB] simultaneous requests, starvation release");
        grantLog = "";
        fork
            begin
                int gl;
                applyStimulus(1'b1, 1'b0, 32'h20, '0, 32'h33334444, 1'b1, 1'b0, gl);
                applyStimulus(1'b1, 1'b0, 32'h24, '0, 32'h55556666, 1'b1, 1'b0, gl);
                applyStimulus(1'b1, 1'b0, 32'h20, '0, 32'h33334444, 1'b1, 1'b0, gl);
                applyStimulus(1'b1, 1'b0, 32'h24, '0, 32'h55556666, 1'b0, 1'b0, gl);
            end
            begin
                int gi;
                applyStimulus(1'b0, 1'b0, 32'h10, '0, 32'h11112222, 1'b0, 1'b0, gi);
            end
        join
        waitDrain();
        checkLog("grant order with starvation", "LLLIL");

        grantLog = "";
        fork
            begin
                int gl;
                applyStimulus(1'b1, 1'b0, 32'h20, '0, 32'h33334444, 1'b1, 1'b0, gl);
                applyStimulus(1'b1, 1'b0, 32'h24, '0, 32'h55556666, 1'b0, 1'b0, gl);
            end
            begin
                int gi;
                applyStimulus(1'b0, 1'b0, 32'h30, '0, 32'hA0A0A0A0, 1'b0, 1'b0, gi);
            end
        join
        waitDrain();
        checkLog("grant order after counter clear", "LLI");

        $display("[TB] back-to-back fetches");
        rv0   = ifRvalidCnt;
        prevG = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, burstAddr[i], '0, burstData[i], i != 3, 1'b0, g);
            if (i > 0) checkOutput("fetch grant spacing", 32'(g - prevG), 32'd2);
            prevG = g;
        end
        waitDrain();
        checkOutput("fetch rvalid pulses", 32'(ifRvalidCnt - rv0), 32'd4);

        $display("[TB] reset during store access");
        grantLog = "";
        fork
            begin
                int gl;
                applyStimulus(1'b1, 1'b0, 32'h20, '0, 32'h33334444, 1'b1, 1'b0, gl);
                applyStimulus(1'b1, 1'b0, 32'h24, '0, 32'h55556666, 1'b1, 1'b0, gl);
                applyStimulus(1'b1, 1'b1, 32'h40, 32'hAA, '0, 1'b0, 1'b1, gl);
                applyStimulus(1'b1, 1'b0, 32'h79, '0, 32'h00000058, 1'b0, 1'b0, gl);
            end
            begin
                int gi;
                applyStimulus(1'b0, 1'b0, 32'h10, '0, 32'h11112222, 1'b0, 1'b0, gi);
            end
        join
        waitDrain();
        checkLog("grant order across reset", "LLLLI");

        $display("[TB] idle bus");
        idleBad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_we || if_gnt || ls_gnt || if_rvalid || ls_rvalid) idleBad++;
        end
        checkOutput("idle bus activity", 32'(idleBad), 32'd0);
        checkOutput("if_rdata held idle", if_rdata, lastIf);
        checkOutput("ls_rdata held idle", ls_rdata, lastLs);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
